// File: rtl/vpu_pkg.sv
// vpu_pkg: shared definitions for the vector VPU.
// Holds default widths, the elementwise opcode encodings understood by vpu_op
// and the sequencer state type used by vpu_vector.
package vpu_pkg;

  localparam int VPU_DATA_W = 32;
  localparam int VPU_ADDR_W = 13;
  localparam int VPU_OP_W   = 10;

  // Opcode encodings decoded by vpu_op; any other value passes operand0 through.
  localparam int OPC_ADD = 0;
  localparam int OPC_SUB = 1;
  localparam int OPC_MUL = 2;
  localparam int OPC_AND = 3;
  localparam int OPC_OR  = 4;
  localparam int OPC_XOR = 5;
  localparam int OPC_MAX = 6;
  localparam int OPC_MIN = 7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_K   = 4'd1,
    ST_K_WAIT = 4'd2,
    ST_RD_A   = 4'd3,
    ST_RD_B   = 4'd4,
    ST_WAIT   = 4'd5,
    ST_CAP_B  = 4'd6,
    ST_WRITE  = 4'd7,
    ST_DONE   = 4'd8
  } vpu_vec_state_t;

endpackage

// File: rtl/vpu_op.sv
// vpu_op: combinational elementwise ALU shared with the scalar VPU.
// Ports: opcode (operation select), operand0/operand1 (element operands),
//        result (operation output, same width as the operands).
// MAX/MIN treat the operands as two's-complement signed values.
module vpu_op
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int OP_W   = VPU_OP_W
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] operand0,
  input  logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] result
);

  // Opcode decode and arithmetic.
  always_comb begin
    result = operand0;
    case (opcode)
      OP_W'(OPC_ADD): result = operand0 + operand1;
      OP_W'(OPC_SUB): result = operand0 - operand1;
      OP_W'(OPC_MUL): result = operand0 * operand1;
      OP_W'(OPC_AND): result = operand0 & operand1;
      OP_W'(OPC_OR):  result = operand0 | operand1;
      OP_W'(OPC_XOR): result = operand0 ^ operand1;
      OP_W'(OPC_MAX): result = ($signed(operand0) > $signed(operand1)) ? operand0 : operand1;
      OP_W'(OPC_MIN): result = ($signed(operand0) < $signed(operand1)) ? operand0 : operand1;
      default:        result = operand0;
    endcase
  end

endmodule

// File: rtl/vpu_vector.sv
// vpu_vector: strided elementwise vector engine on a shared single-port BRAM.
// Ports: clk/rst_n (clock, async active-low reset); start + command inputs
//        (opcode, use_const, base_a/b/c, const_addr, stride_a/b/c, len);
//        bram_addr/bram_din/bram_en/bram_we drive the BRAM, bram_dout returns
//        read data RD_LAT cycles after the address is seen; busy/done status.
// Every output is a register, so each state's bus values appear one cycle
// after the state itself.
module vpu_vector
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int ADDR_W = VPU_ADDR_W,
  parameter int OP_W   = VPU_OP_W,
  parameter int LEN_W  = 13,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic              use_const,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] const_addr,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [ADDR_W-1:0] stride_b,
  input  logic [ADDR_W-1:0] stride_c,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              bram_en,
  output logic              bram_we,
  output logic              busy,
  output logic              done
);

  localparam int WAIT_W = $clog2(RD_LAT + 2);

  vpu_vec_state_t state_r, state_s;

  logic [OP_W-1:0]   opcode_r;
  logic              use_const_r;
  logic [ADDR_W-1:0] const_addr_r, stride_a_r, stride_b_r, stride_c_r;
  logic [ADDR_W-1:0] ptr_a_r, ptr_b_r, ptr_c_r;
  logic [LEN_W-1:0]  len_r, cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s, wait_last_s;
  logic [DATA_W-1:0] a_r, b_r, k_r, op_b_s, op_res_s;

  logic [ADDR_W-1:0] bram_addr_r, addr_s;
  logic [DATA_W-1:0] bram_din_r, din_s;
  logic              bram_en_r, en_s, bram_we_r, we_s;
  logic              busy_r, busy_s, done_r, done_s;
  logic              accept_s, cap_k_s, cap_a_s, cap_b_s, adv_s;

  assign bram_addr = bram_addr_r;
  assign bram_din  = bram_din_r;
  assign bram_en   = bram_en_r;
  assign bram_we   = bram_we_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Const mode folds the RD_B slot into the wait, so A needs one extra cycle.
  assign wait_last_s = use_const_r ? WAIT_W'(RD_LAT) : WAIT_W'(RD_LAT - 1);
  assign op_b_s      = use_const_r ? k_r : b_r;

  vpu_op #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W)
  ) u_op (
    .opcode  (opcode_r),
    .operand0(a_r),
    .operand1(op_b_s),
    .result  (op_res_s)
  );

  // Next-state logic and next values of the registered bus outputs.
  always_comb begin
    state_s    = state_r;
    addr_s     = bram_addr_r;
    din_s      = bram_din_r;
    en_s       = bram_en_r;
    we_s       = 1'b0;
    done_s     = 1'b0;
    busy_s     = 1'b0;
    wait_cnt_s = '0;
    accept_s   = 1'b0;
    cap_k_s    = 1'b0;
    cap_a_s    = 1'b0;
    cap_b_s    = 1'b0;
    adv_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (len == '0) begin
            state_s = ST_DONE;
          end else if (use_const) begin
            state_s = ST_LD_K;
          end else begin
            state_s = ST_RD_A;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LD_K: begin
        addr_s  = const_addr_r;
        en_s    = 1'b1;
        state_s = ST_K_WAIT;
      end
      ST_K_WAIT: begin
        if (wait_cnt_r == WAIT_W'(RD_LAT)) begin
          cap_k_s = 1'b1;
          state_s = ST_RD_A;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_RD_A: begin
        addr_s  = ptr_a_r;
        en_s    = 1'b1;
        state_s = use_const_r ? ST_WAIT : ST_RD_B;
      end
      ST_RD_B: begin
        addr_s  = ptr_b_r;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_r == wait_last_s) begin
          cap_a_s = 1'b1;
          state_s = use_const_r ? ST_WRITE : ST_CAP_B;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_CAP_B: begin
        cap_b_s = 1'b1;
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        addr_s = ptr_c_r;
        din_s  = op_res_s;
        we_s   = 1'b1;
        adv_s  = 1'b1;
        if (cnt_r + LEN_W'(1) == len_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RD_A;
        end
      end
      ST_DONE: begin
        en_s    = 1'b0;
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr_r <= '0;
      bram_din_r  <= '0;
      bram_en_r   <= 1'b0;
      bram_we_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      bram_addr_r <= addr_s;
      bram_din_r  <= din_s;
      bram_en_r   <= en_s;
      bram_we_r   <= we_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // Command latch, pointers, counters and operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_r     <= '0;
      use_const_r  <= 1'b0;
      const_addr_r <= '0;
      stride_a_r   <= '0;
      stride_b_r   <= '0;
      stride_c_r   <= '0;
      ptr_a_r      <= '0;
      ptr_b_r      <= '0;
      ptr_c_r      <= '0;
      len_r        <= '0;
      cnt_r        <= '0;
      wait_cnt_r   <= '0;
      a_r          <= '0;
      b_r          <= '0;
      k_r          <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_s;
      if (accept_s) begin
        opcode_r     <= opcode;
        use_const_r  <= use_const;
        const_addr_r <= const_addr;
        stride_a_r   <= stride_a;
        stride_b_r   <= stride_b;
        stride_c_r   <= stride_c;
        ptr_a_r      <= base_a;
        ptr_b_r      <= base_b;
        ptr_c_r      <= base_c;
        len_r        <= len;
        cnt_r        <= '0;
      end else if (adv_s) begin
        // Pointer sums wrap silently at 2^ADDR_W.
        ptr_a_r <= ptr_a_r + stride_a_r;
        ptr_b_r <= ptr_b_r + stride_b_r;
        ptr_c_r <= ptr_c_r + stride_c_r;
        cnt_r   <= cnt_r + LEN_W'(1);
      end
      if (cap_k_s) k_r <= bram_dout;
      if (cap_a_s) a_r <= bram_dout;
      if (cap_b_s) b_r <= bram_dout;
    end
  end

endmodule

// File: tb/tb_vpu_vector.sv
// tb_vpu_vector: self-checking bench for vpu_vector with a behavioural BRAM,
// a directed vector table, randomized commands and a mid-operation reset.
module tb_vpu_vector;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 13;
  localparam int OP_W    = 10;
  localparam int LEN_W   = 13;
  localparam int RD_LAT  = 2;
  localparam int MEM_N   = 8192;
  localparam int MAX_CYC = 400;

  logic              clk, rst_n, start, use_const, bram_en, bram_we, busy, done;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] base_a, base_b, base_c, const_addr, stride_a, stride_b, stride_c, bram_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] bram_din, bram_dout;

  vpu_vector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .use_const(use_const),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .const_addr(const_addr),
    .stride_a(stride_a), .stride_b(stride_b), .stride_c(stride_c), .len(len),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .bram_en(bram_en), .bram_we(bram_we), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: address seen in cycle t, data valid in cycle t+RD_LAT.
  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  assign bram_dout = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bram_en && bram_we) mem[bram_addr] = bram_din;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_op(input int op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return ($signed(a) > $signed(b)) ? a : b;
      7: return ($signed(a) < $signed(b)) ? a : b;
      default: return a;
    endcase
  endfunction

  typedef struct {
    logic        uc;
    int          len;
    int          ka;
    logic [31:0] kval;
    int          ba, bb, bc, sa, sb, sc;
    int          op;
    int          exp_first_we;
    int          exp_done;
  } vec_t;

  // Reference model state and per-cycle history of the bus.
  logic [DATA_W-1:0] mm [MEM_N];
  int                exp_pa [$], exp_pb [$], exp_pc [$];
  logic [DATA_W-1:0] exp_dat [$];
  logic [ADDR_W-1:0] addr_h [MAX_CYC+1];
  logic [DATA_W-1:0] din_h  [MAX_CYC+1];
  logic              en_h [MAX_CYC+1], we_h [MAX_CYC+1], busy_h [MAX_CYC+1];

  // Launch one command (caller is at a negedge), watch it to done, check it.
  task automatic run_cmd(input vec_t v, input int inject_cyc);
    int done_cyc, last, nw, per, rd0;
    logic [DATA_W-1:0] kv, a, b, r;
    exp_pa.delete(); exp_pb.delete(); exp_pc.delete(); exp_dat.delete();
    for (int i = 0; i < MEM_N; i++) mm[i] = mem[i];
    kv = mm[v.ka];
    for (int k = 0; k < v.len; k++) begin
      exp_pa.push_back((v.ba + k * v.sa) % MEM_N);
      exp_pb.push_back((v.bb + k * v.sb) % MEM_N);
      exp_pc.push_back((v.bc + k * v.sc) % MEM_N);
      a = mm[exp_pa[k]];
      b = v.uc ? kv : mm[exp_pb[k]];
      r = ref_op(v.op, a, b);
      mm[exp_pc[k]] = r;
      exp_dat.push_back(r);
    end
    for (int n = 0; n <= MAX_CYC; n++) begin
      addr_h[n] = '0; din_h[n] = '0; en_h[n] = 1'b0; we_h[n] = 1'b0; busy_h[n] = 1'b0;
    end
    use_const = v.uc; len = LEN_W'(v.len); const_addr = ADDR_W'(v.ka);
    base_a = ADDR_W'(v.ba); base_b = ADDR_W'(v.bb); base_c = ADDR_W'(v.bc);
    stride_a = ADDR_W'(v.sa); stride_b = ADDR_W'(v.sb); stride_c = ADDR_W'(v.sc);
    opcode = OP_W'(v.op);
    start = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    for (int n = 1; n <= MAX_CYC; n++) begin
      @(negedge clk);
      if (n == inject_cyc) begin
        start = 1'b1; len = LEN_W'(5); base_c = ADDR_W'(50); use_const = 1'b0;
      end else begin
        start = 1'b0;
      end
      addr_h[n] = bram_addr; din_h[n] = bram_din; en_h[n] = bram_en;
      we_h[n] = bram_we; busy_h[n] = busy;
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    chk("done_cycle", done_cyc, v.exp_done);
    last = (done_cyc < 0) ? MAX_CYC : done_cyc;
    chk("busy_cycle1", busy_h[1], 1);
    if (done_cyc > 0) begin
      chk("busy_at_done", busy_h[done_cyc], 0);
      chk("en_at_done", en_h[done_cyc], 0);
    end
    per = v.uc ? RD_LAT + 3 : RD_LAT + 4;
    nw = 0;
    for (int n = 1; n <= last; n++) begin
      if (we_h[n]) begin
        if (nw < v.len) begin
          chk("we_cycle", n, v.exp_first_we + per * nw);
          chk("we_addr", addr_h[n], exp_pc[nw]);
          chk("we_data", din_h[n], exp_dat[nw]);
        end
        nw++;
      end
    end
    chk("write_count", nw, v.len);
    rd0 = v.uc ? RD_LAT + 4 : 2;
    if (v.uc && v.len > 0) chk("rd_const_addr", addr_h[2], v.ka);
    for (int k = 0; k < v.len; k++) begin
      if (rd0 + per * k + 1 <= last) begin
        chk("rd_a_addr", addr_h[rd0 + per * k], exp_pa[k]);
        chk("rd_a_en", en_h[rd0 + per * k], 1);
        if (!v.uc) chk("rd_b_addr", addr_h[rd0 + per * k + 1], exp_pb[k]);
      end
    end
    if (v.len == 0) begin
      nw = 0;
      for (int n = 1; n <= last; n++) if (en_h[n]) nw++;
      chk("zero_len_no_en", nw, 0);
    end
  endtask

  vec_t tbl [6];
  vec_t rv;

  initial begin
    int wcount, dcount;
    rst_n = 1'b0; start = 1'b0; use_const = 1'b0; opcode = '0; len = '0;
    base_a = '0; base_b = '0; base_c = '0; const_addr = '0;
    stride_a = '0; stride_b = '0; stride_c = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;

    //         uc    len ka   kval   ba   bb   bc    sa sb sc op first done
    tbl[0] = '{1'b0, 4,  0,   0,     0,   16,  32,   1, 1, 1, 0, 7,    26};
    tbl[1] = '{1'b1, 3,  100, 5,     200, 0,   300,  1, 0, 1, 0, 10,   21};
    tbl[2] = '{1'b0, 0,  0,   0,     0,   0,   0,    1, 1, 1, 0, 0,    2};
    tbl[3] = '{1'b0, 3,  0,   0,     400, 500, 8190, 1, 1, 1, 0, 7,    20};
    tbl[4] = '{1'b0, 3,  0,   0,     600, 601, 600,  0, 1, 0, 0, 7,    20};
    tbl[5] = '{1'b1, 2,  700, 9,     710, 0,   720,  2, 0, 3, 1, 10,   16};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", bram_addr, 0); chk("rst_din", bram_din, 0);
    chk("rst_en", bram_en, 0);     chk("rst_we", bram_we, 0);
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; rows 0 and 1 also pulse start while busy.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].uc) mem[tbl[i].ka] = tbl[i].kval;
      run_cmd(tbl[i], (i == 0) ? 3 : ((i == 1) ? 12 : 0));
    end

    // Randomized commands, each launched on the previous done cycle.
    for (int r = 0; r < 14; r++) begin
      rv.uc = 1'($urandom_range(0, 1));
      rv.len = $urandom_range(0, 10);
      rv.ka = $urandom_range(0, MEM_N - 1);
      rv.kval = mem[rv.ka];
      rv.ba = $urandom_range(0, MEM_N - 1);
      rv.bb = $urandom_range(0, MEM_N - 1);
      rv.bc = $urandom_range(0, MEM_N - 1);
      rv.sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_N - 1) : $urandom_range(0, 3);
      rv.sb = $urandom_range(0, 3);
      rv.sc = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        rv.bc = rv.ba; rv.sc = rv.sa;
      end
      rv.op = $urandom_range(0, 8);
      rv.exp_first_we = rv.uc ? (RD_LAT + 2) + (RD_LAT + 3) + 1 : (RD_LAT + 4) + 1;
      rv.exp_done = (rv.len == 0) ? 2 :
                    rv.exp_first_we + (rv.uc ? RD_LAT + 3 : RD_LAT + 4) * (rv.len - 1) + 1;
      run_cmd(rv, 0);
    end

    // One-cycle done pulse after the last command.
    @(negedge clk);
    chk("done_pulse_width", done, 0);

    // Reset during the WAIT of element 1 of a binary command.
    use_const = 1'b0; len = LEN_W'(3); opcode = '0;
    base_a = ADDR_W'(1000); base_b = ADDR_W'(1100); base_c = ADDR_W'(1200);
    stride_a = ADDR_W'(1); stride_b = ADDR_W'(1); stride_c = ADDR_W'(1);
    start = 1'b1;
    @(posedge clk);
    wcount = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (bram_we) wcount++;
    end
    chk("pre_reset_writes", wcount, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", bram_addr, 0); chk("midrst_din", bram_din, 0);
    chk("midrst_en", bram_en, 0);     chk("midrst_we", bram_we, 0);
    chk("midrst_busy", busy, 0);      chk("midrst_done", done, 0);
    wcount = 0; dcount = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 2) rst_n = 1'b1;
      if (bram_we) wcount++;
      if (done) dcount++;
    end
    chk("post_reset_writes", wcount, 0);
    chk("post_reset_done", dcount, 0);

    // Recovery: a normal command after the reset.
    run_cmd(tbl[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
